// File: rtl/wallace_seq_mul.sv
// -----------------------------------------------------------------------------
// wallace_seq_mul
//   Sequential unsigned multiplier built around a single combinational 4x4
//   Wallace (carry-save) core. An operand pair of 4*SLICES bits is split into
//   nibbles. The SLICES^2 nibble-pair partial products are pushed through the
//   core one per cycle and summed into a shifted accumulator.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand pair valid (producer side)
//   in_ready     controller can accept an operand pair
//   in_a, in_b   unsigned operands, 4*SLICES bits
//   out_valid    product valid (consumer side)
//   out_ready    consumer accepts the product
//   out_p        unsigned product, 8*SLICES bits
//   busy         high while an operation is in flight (CALC or DONE)
//   dbg_state_o  current controller state (0 IDLE, 1 CALC, 2 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The source holds valid and data stable until it sees ready.
// Once out_valid is raised, out_valid and out_p stay stable until accepted.
// -----------------------------------------------------------------------------
module wallace_seq_mul #(
  parameter int SLICES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*SLICES-1:0]   in_a,
  input  logic [4*SLICES-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*SLICES-1:0]   out_p,
  output logic                  busy,
  output logic [1:0]            dbg_state_o
);

  localparam int OW = 4 * SLICES;
  localparam int PW = 8 * SLICES;
  // Counter width; a one-slice build still needs a 1-bit counter, held at 0.
  localparam int CW = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [OW-1:0]   a_q, b_q;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   out_p_q;
  logic            out_valid_q;
  logic [CW-1:0]   i_q, j_q;

  // ---------------------------------------------------------------------------
  // 4x4 Wallace core: four shifted partial-product rows, reduced by two
  // carry-save stages, then a single carry-propagate add. The true product
  // fits in 8 bits, so carries shifted past bit 7 are always zero.
  // ---------------------------------------------------------------------------
  logic [3:0] core_x, core_y;
  logic [7:0] pp [4];
  logic [7:0] s1, c1, s2, c2;
  logic [7:0] core_out;
  logic [CW:0] sh_nib;
  logic [PW-1:0] term;

  always_comb begin
    core_x = 4'(a_q >> (4 * i_q));
    core_y = 4'(b_q >> (4 * j_q));
    for (int r = 0; r < 4; r++) begin
      pp[r] = {4'b0000, core_x & {4{core_y[r]}}} << r;
    end
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2 = s1 ^ c1 ^ pp[3];
    c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    core_out = s2 + c2;
    // Partial product of nibbles i and j has weight 16^(i+j).
    sh_nib = {1'b0, i_q} + {1'b0, j_q};
    term   = PW'(core_out) << (4 * sh_nib);
    acc_d  = acc_q + term;
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          if (i_q == LAST && j_q == LAST) begin
            // Last pass: publish acc+term directly, no extra cycle.
            out_p_q     <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + CW'(1);
          end else begin
            j_q <= j_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_p       = out_p_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wallace_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_wallace_seq_mul
//   Directed and random checks of wallace_seq_mul at SLICES=2, plus random
//   stress of SLICES=1 and SLICES=3 instances running alongside.
// -----------------------------------------------------------------------------
module tb_wallace_seq_mul;

  localparam int S  = 2;
  localparam int OW = 4 * S;
  localparam int PW = 8 * S;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [OW-1:0] in_a, in_b;
  logic [PW-1:0] out_p;
  logic [1:0]    dbg_state;

  int cyc = 0;
  always @(posedge clk) cyc++;

  wallace_seq_mul #(.SLICES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .busy(busy), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_pass = 0, n_fail = 0, n_checks = 0;
  logic [PW-1:0] exp_q[$];
  int n_pushed = 0, n_seen = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // A product transfers on the next rising edge when valid&ready at negedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("product", out_p, exp_q.pop_front());
      n_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic drive_op(input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input bit push, output int acc_cyc);
    int budget;
    budget   = 0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    if (push) begin
      exp_q.push_back(PW'(a) * PW'(b));
      n_pushed++;
    end
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) check("accept_timeout", budget, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic wait_drain(input int limit);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || busy) && budget < limit) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= limit) check("drain_timeout", budget, 0);
  endtask

  // ---------------- extra builds: SLICES=1 and SLICES=3 ----------------
  for (genvar g = 0; g < 2; g++) begin : g_alt
    localparam int SS  = (g == 0) ? 1 : 3;
    localparam int AOW = 4 * SS;
    localparam int APW = 8 * SS;

    logic           a_rst, a_iv, a_ir, a_ov, a_or, a_busy;
    logic [AOW-1:0] a_a, a_b;
    logic [APW-1:0] a_p;
    logic [1:0]     a_dbg;
    logic [APW-1:0] a_exp_q[$];
    int             a_n_push = 0, a_n_seen = 0;
    bit             a_done = 1'b0, a_stop = 1'b0;

    wallace_seq_mul #(.SLICES(SS)) u_alt (
      .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir),
      .in_a(a_a), .in_b(a_b), .out_valid(a_ov), .out_ready(a_or),
      .out_p(a_p), .busy(a_busy), .dbg_state_o(a_dbg)
    );

    always @(negedge clk) begin
      if (!a_rst && a_ov && a_or) begin
        check("alt_queue_nonempty", 64'(a_exp_q.size() != 0), 64'd1);
        if (a_exp_q.size() != 0) check("alt_product", a_p, a_exp_q.pop_front());
        a_n_seen++;
      end
    end

    initial begin
      int bud;
      a_rst = 1'b1; a_iv = 1'b0; a_a = '0; a_b = '0; a_or = 1'b0;
      repeat (3) @(posedge clk);
      #1 a_rst = 1'b0;
      fork
        begin
          for (int k = 0; k < 300; k++) begin
            int wb;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            a_a  = AOW'($urandom());
            a_b  = AOW'($urandom());
            if (k == 0) begin a_a = '1; a_b = '1; end
            a_iv = 1'b1;
            a_exp_q.push_back(APW'(a_a) * APW'(a_b));
            a_n_push++;
            wb = 0;
            while (!a_ir && wb < 200) begin @(posedge clk); #1; wb++; end
            if (wb >= 200) check("alt_accept_timeout", wb, 0);
            @(posedge clk); #1;
            a_iv = 1'b0;
          end
          a_stop = 1'b1;
        end
        begin
          while (!a_stop) begin
            @(posedge clk); #1;
            a_or = ($urandom_range(0, 3) != 0);
          end
        end
      join
      a_or = 1'b1;
      bud = 0;
      while ((a_exp_q.size() != 0 || a_busy) && bud < 500) begin
        @(posedge clk); #1;
        bud++;
      end
      if (bud >= 500) check("alt_drain_timeout", bud, 0);
      check("alt_count", a_n_seen, a_n_push);
      a_done = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int t1, t2, bud;
    bit rnd_done;
    rnd_done = 1'b0;

    // 1: reset held 3 cycles
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_p", out_p, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", in_ready, 1);
    check("rel_busy", busy, 0);

    // 2: 0x0D * 0x0B, consumer not ready until the result appears
    drive_op(8'h0D, 8'h0B, 1'b1, t1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("t2_busy", busy, 1);
      check("t2_in_ready", in_ready, 0);
      check("t2_out_valid", out_valid, 64'(k == 4));
    end
    check("t2_out_p", out_p, 16'h008F);
    check("t2_state_done", dbg_state, 2);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t2_idle_busy", busy, 0);
    check("t2_idle_valid", out_valid, 0);
    check("t2_p_kept", out_p, 16'h008F);
    out_ready = 1'b0;

    // 3: 0xFF * 0xFF held for 5 cycles of backpressure
    drive_op(8'hFF, 8'hFF, 1'b1, t1);
    repeat (4) begin @(posedge clk); #1; end
    check("t3_valid", out_valid, 1);
    check("t3_out_p", out_p, 16'hFE01);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_p", out_p, 16'hFE01);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_idle_busy", busy, 0);
    check("t3_idle_ready", in_ready, 1);
    check("t3_idle_valid", out_valid, 0);

    // 4: back-to-back with out_ready held high
    drive_op(8'h00, 8'hA7, 1'b1, t1);
    drive_op(8'h01, 8'hA7, 1'b1, t2);
    check("t4_interval", t2 - t1, 6);
    wait_drain(50);
    check("t4_last_p", out_p, 16'h00A7);

    // 5: reset on the second CALC edge abandons the operation
    drive_op(8'h12, 8'h34, 1'b0, t1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t5_busy", busy, 0);
    check("t5_valid", out_valid, 0);
    check("t5_out_p", out_p, 0);
    check("t5_in_ready_rst", in_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("t5_no_valid", out_valid, 0);
    end
    drive_op(8'h12, 8'h34, 1'b1, t1);
    wait_drain(50);
    check("t5_out_p", out_p, 16'h03A8);

    // 6: random operands with producer and consumer stalls
    fork
      begin
        for (int k = 0; k < 2000; k++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          drive_op(OW'($urandom()), OW'($urandom()), 1'b1, t1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(500);
    check("t6_count", n_seen, n_pushed);

    bud = 0;
    while (!(g_alt[0].a_done && g_alt[1].a_done) && bud < 20000) begin
      @(posedge clk); #1;
      bud++;
    end
    if (bud >= 20000) check("alt_done_timeout", bud, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
